// File: rtl/clk_prog_detector.sv
// clk_prog_detector
//   Receive-side decoder for the programmable clock divider. Measures the
//   half-period of the divided slow clock (i_clk_2_in) in the i_clk domain,
//   maps it back to the 3-bit programming code that produced it and reports
//   lock / mismatch / stall status.
//
//   Optional feature (macro FREQ_MON_CLK1_CHECK_EN): a second monitor checks
//   the fixed 10 Hz clock (i_clk_1_in) half-period against code-0 timing and
//   drives o_clk1_fault. When the macro is undefined o_clk1_fault is 0 and
//   i_clk_1_in is ignored.
//
// Ports
//   i_clk          system clock (100 MHz)
//   i_rst          asynchronous active-high reset
//   i_clk_1_in     10 Hz clock under observation (optional feature only)
//   i_clk_2_in     programmable slow clock under observation
//   o_prog_det     decoded programming code
//   o_locked       o_prog_det confirmed and current
//   o_det_update   1-cycle pulse when o_prog_det changes or first locks
//   o_mismatch     1-cycle pulse when an interval matches no code
//   o_stall        no i_clk_2_in edge seen for T_MAX cycles
//   o_half_period  last measured interval in i_clk cycles
//   o_clk1_fault   10 Hz clock out of tolerance
//
// Timing: an input toggle is first sampled on edge A, reaches the edge
// detector after edge A+1 and the resulting outputs register on edge A+2.
module clk_prog_detector #(
  parameter int unsigned UNIT      = 2500000,
  parameter int unsigned TOL_SHIFT = 4,
  parameter int unsigned MATCH_CNT = 2,
  parameter int unsigned CNT_W     = 30
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clk_1_in,
  input  logic             i_clk_2_in,
  output logic [2:0]       o_prog_det,
  output logic             o_locked,
  output logic             o_det_update,
  output logic             o_mismatch,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_half_period,
  output logic             o_clk1_fault
);

  // Expected half-period for code c, evaluated at elaboration.
  function automatic longint unsigned f_exp(input int c);
    longint unsigned m;
    case (c)
      0:       m = 2;
      1:       m = 4;
      2:       m = 8;
      3:       m = 16;
      4:       m = 25;
      5:       m = 50;
      6:       m = 100;
      default: m = 200;
    endcase
    return m * longint'(UNIT);
  endfunction

  function automatic longint unsigned f_tol(input int c);
    return f_exp(c) >> TOL_SHIFT;
  endfunction

  localparam longint unsigned L_TMAX   = f_exp(7) + f_tol(7) + 1;
  localparam logic [CNT_W-1:0] L_TMAX_C = L_TMAX[CNT_W-1:0];
  localparam int MC_W                  = $clog2(MATCH_CNT + 1);
  localparam logic [MC_W-1:0] L_MC     = MC_W'(MATCH_CNT);

  typedef enum logic {S_SYNC, S_MEAS} state_t;

  // ---------------------------------------------------------------- regs
  state_t           r_state;
  logic [2:0]       r_c2_s;      // [0]=sync1, [1]=sync2, [2]=sync3
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_cand;
  logic [MC_W-1:0]  r_mcnt;
  logic [2:0]       r_prog;
  logic             r_locked;
  logic             r_det;
  logic             r_mism;
  logic             r_stall;
  logic [CNT_W-1:0] r_half;

  // ---------------------------------------------------------------- wires
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_cand_nxt;
  logic [MC_W-1:0]  w_mcnt_nxt;
  logic [2:0]       w_prog_nxt;
  logic             w_locked_nxt;
  logic             w_det_nxt;
  logic             w_mism_nxt;
  logic             w_stall_nxt;
  logic [CNT_W-1:0] w_half_nxt;

  logic             w_edge;
  logic [63:0]      w_p;
  logic             w_hit;
  logic [2:0]       w_code;
  logic [MC_W-1:0]  w_mc_inc;
  logic [MC_W-1:0]  w_mc_new;

  assign w_edge   = r_c2_s[1] ^ r_c2_s[2];
  assign w_mc_inc = (r_mcnt == L_MC) ? L_MC : r_mcnt + MC_W'(1);
  assign w_mc_new = (w_code == r_cand) ? w_mc_inc : MC_W'(1);

  // Classifier. Scanning from code 7 down lets the lowest matching code win.
  // The lower bound is written as P + tol >= E to stay unsigned-safe.
  always_comb begin
    w_p    = 64'(r_cnt);
    w_hit  = 1'b0;
    w_code = 3'd0;
    for (int c = 7; c >= 0; c--) begin
      if ((w_p + f_tol(c) >= f_exp(c)) && (w_p <= f_exp(c) + f_tol(c))) begin
        w_hit  = 1'b1;
        w_code = 3'(c);
      end
    end
  end

  // Next-state / output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cand_nxt   = r_cand;
    w_mcnt_nxt   = r_mcnt;
    w_prog_nxt   = r_prog;
    w_locked_nxt = r_locked;
    w_det_nxt    = 1'b0;
    w_mism_nxt   = 1'b0;
    w_stall_nxt  = r_stall;
    w_half_nxt   = r_half;
    case (r_state)
      S_SYNC: begin
        // First partial interval is thrown away: just arm the counter.
        w_cnt_nxt = '0;
        if (w_edge) begin
          w_cnt_nxt   = CNT_W'(1);
          w_stall_nxt = 1'b0;
          w_state_nxt = S_MEAS;
        end
      end
      S_MEAS: begin
        if (w_edge) begin
          // An edge wins over a timeout landing in the same cycle.
          w_cnt_nxt  = CNT_W'(1);
          w_half_nxt = r_cnt;
          if (w_hit) begin
            w_cand_nxt = w_code;
            w_mcnt_nxt = w_mc_new;
            if (w_mc_new == L_MC) begin
              w_prog_nxt   = w_code;
              w_locked_nxt = 1'b1;
              w_det_nxt    = (r_prog != w_code) || !r_locked;
            end else if (w_code != r_prog) begin
              w_locked_nxt = 1'b0;
            end
          end else begin
            w_mism_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
            w_mcnt_nxt   = '0;
          end
        end else if (r_cnt == L_TMAX_C) begin
          // Stall: drop lock, keep the last code, resynchronise.
          w_stall_nxt  = 1'b1;
          w_locked_nxt = 1'b0;
          w_mcnt_nxt   = '0;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SYNC;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_SYNC;
      r_c2_s   <= '0;
      r_cnt    <= '0;
      r_cand   <= '0;
      r_mcnt   <= '0;
      r_prog   <= '0;
      r_locked <= 1'b0;
      r_det    <= 1'b0;
      r_mism   <= 1'b0;
      r_stall  <= 1'b0;
      r_half   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_c2_s   <= {r_c2_s[1:0], i_clk_2_in};
      r_cnt    <= w_cnt_nxt;
      r_cand   <= w_cand_nxt;
      r_mcnt   <= w_mcnt_nxt;
      r_prog   <= w_prog_nxt;
      r_locked <= w_locked_nxt;
      r_det    <= w_det_nxt;
      r_mism   <= w_mism_nxt;
      r_stall  <= w_stall_nxt;
      r_half   <= w_half_nxt;
    end
  end

  assign o_prog_det    = r_prog;
  assign o_locked      = r_locked;
  assign o_det_update  = r_det;
  assign o_mismatch    = r_mism;
  assign o_stall       = r_stall;
  assign o_half_period = r_half;

`ifdef FREQ_MON_CLK1_CHECK_EN
  // 10 Hz monitor: same sampling and interval scheme as above, checked
  // against the code-0 window only.
  localparam longint unsigned L_T1   = f_exp(0) + f_tol(0) + 1;
  localparam logic [CNT_W-1:0] L_T1_C = L_T1[CNT_W-1:0];

  logic [2:0]       r_c1_s;
  logic             r_c1_run;
  logic [CNT_W-1:0] r_c1_cnt;
  logic [MC_W-1:0]  r_c1_good;
  logic             r_clk1_fault;
  logic             w_c1_edge;
  logic             w_c1_inwin;
  logic [MC_W-1:0]  w_c1_good_inc;

  assign w_c1_edge     = r_c1_s[1] ^ r_c1_s[2];
  assign w_c1_inwin    = (64'(r_c1_cnt) + f_tol(0) >= f_exp(0)) &&
                         (64'(r_c1_cnt) <= f_exp(0) + f_tol(0));
  assign w_c1_good_inc = (r_c1_good == L_MC) ? L_MC : r_c1_good + MC_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_c1_s       <= '0;
      r_c1_run     <= 1'b0;
      r_c1_cnt     <= '0;
      r_c1_good    <= '0;
      r_clk1_fault <= 1'b0;
    end else begin
      r_c1_s <= {r_c1_s[1:0], i_clk_1_in};
      if (!r_c1_run) begin
        r_c1_cnt <= '0;
        if (w_c1_edge) begin
          r_c1_run <= 1'b1;
          r_c1_cnt <= CNT_W'(1);
        end
      end else if (w_c1_edge) begin
        r_c1_cnt <= CNT_W'(1);
        if (w_c1_inwin) begin
          r_c1_good <= w_c1_good_inc;
          if (w_c1_good_inc == L_MC) r_clk1_fault <= 1'b0;
        end else begin
          r_c1_good    <= '0;
          r_clk1_fault <= 1'b1;
        end
      end else if (r_c1_cnt == L_T1_C) begin
        r_c1_good    <= '0;
        r_clk1_fault <= 1'b1;
        r_c1_run     <= 1'b0;
        r_c1_cnt     <= '0;
      end else begin
        r_c1_cnt <= r_c1_cnt + CNT_W'(1);
      end
    end
  end

  assign o_clk1_fault = r_clk1_fault;
`else
  logic w_unused_clk1;
  assign w_unused_clk1 = i_clk_1_in;
  assign o_clk1_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_prog_detector.sv
// Bench for clk_prog_detector with UNIT=4, TOL_SHIFT=4, MATCH_CNT=2
// (E = 8,16,32,64,100,200,400,800; T_MAX = 851).
// Inputs are toggled on falling clk edges; the model works on the index of
// the rising edge that samples each toggle and its outputs appear two rising
// edges later on the DUT.
module tb_clk_prog_detector;

  localparam int UNIT  = 4;
  localparam int TMAX  = 851;
  localparam int T1    = 9;
  localparam int MATCH = 2;

  // ------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk1 = 1'b0;
  logic clk2 = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  o_prog_det;
  logic        o_locked, o_det_update, o_mismatch, o_stall, o_clk1_fault;
  logic [29:0] o_half_period;

  clk_prog_detector #(
    .UNIT(4), .TOL_SHIFT(4), .MATCH_CNT(2), .CNT_W(30)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_1_in(clk1), .i_clk_2_in(clk2),
    .o_prog_det(o_prog_det), .o_locked(o_locked),
    .o_det_update(o_det_update), .o_mismatch(o_mismatch),
    .o_stall(o_stall), .o_half_period(o_half_period),
    .o_clk1_fault(o_clk1_fault)
  );

  // ------------------------------------------------------- model
  typedef struct packed {
    logic [2:0]  prog;
    logic        locked;
    logic        det;
    logic        mism;
    logic        stall;
    logic [29:0] half;
    logic        f1;
  } exp_t;

  exp_t exp_q[$];
  int   mult[8] = '{2, 4, 8, 16, 25, 50, 100, 200};

  int   n, m_last2, m_cand, m_mcnt, m_prog, m_half, m_p, m_code;
  bit   m_prev2, m_meas, m_locked, m_det, m_mism, m_stall, m_hit;
  int   m_last1, m_good1;
  bit   m_prev1, m_run1, m_f1;

  function automatic exp_t m_pack();
    exp_t e;
    e.prog = 3'(m_prog); e.locked = m_locked; e.det = m_det;
    e.mism = m_mism; e.stall = m_stall; e.half = 30'(m_half); e.f1 = m_f1;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n = 0; m_last2 = 0; m_cand = 0; m_mcnt = 0; m_prog = 0; m_half = 0;
      m_prev2 = 0; m_meas = 0; m_locked = 0; m_det = 0; m_mism = 0;
      m_stall = 0; m_last1 = 0; m_good1 = 0; m_prev1 = 0; m_run1 = 0;
      m_f1 = 0;
      exp_q.delete();
      exp_q.push_back(m_pack());
      exp_q.push_back(m_pack());
    end else begin
      n++;
      m_det = 0;
      m_mism = 0;
      if (!m_meas) begin
        if (clk2 != m_prev2) begin
          m_meas = 1; m_last2 = n; m_stall = 0;
        end
      end else if (clk2 != m_prev2) begin
        m_p = n - m_last2;
        m_last2 = n;
        m_half = m_p;
        m_hit = 0;
        m_code = 0;
        for (int c = 0; c < 8; c++) begin
          int e, t;
          e = UNIT * mult[c];
          t = e >> 4;
          if (!m_hit && m_p >= e - t && m_p <= e + t) begin
            m_hit = 1; m_code = c;
          end
        end
        if (m_hit) begin
          if (m_code == m_cand) m_mcnt = (m_mcnt + 1 > MATCH) ? MATCH : m_mcnt + 1;
          else begin m_cand = m_code; m_mcnt = 1; end
          if (m_mcnt == MATCH) begin
            m_det = (m_prog != m_cand) || !m_locked;
            m_prog = m_cand;
            m_locked = 1;
          end else if (m_code != m_prog) m_locked = 0;
        end else begin
          m_mism = 1; m_locked = 0; m_mcnt = 0;
        end
      end else if (n - m_last2 == TMAX) begin
        m_stall = 1; m_locked = 0; m_meas = 0; m_mcnt = 0;
      end
      m_prev2 = clk2;
`ifdef FREQ_MON_CLK1_CHECK_EN
      if (!m_run1) begin
        if (clk1 != m_prev1) begin m_run1 = 1; m_last1 = n; end
      end else if (clk1 != m_prev1) begin
        if (n - m_last1 == 2 * UNIT) begin
          m_good1 = (m_good1 + 1 > MATCH) ? MATCH : m_good1 + 1;
          if (m_good1 == MATCH) m_f1 = 0;
        end else begin
          m_good1 = 0; m_f1 = 1;
        end
        m_last1 = n;
      end else if (n - m_last1 == T1) begin
        m_f1 = 1; m_good1 = 0; m_run1 = 0;
      end
      m_prev1 = clk1;
`endif
      exp_q.push_back(m_pack());
      if (exp_q.size() > 3) void'(exp_q.pop_front());
    end
  end

  // ------------------------------------------------------- scoreboard
  int   n_chk = 0;
  int   n_err = 0;
  int   det_cnt = 0;
  int   mism_cnt = 0;
  exp_t cmp_e;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ------------------------------------------------------- drivers
  int s1 = 0;
  int s2 = 0;

  task automatic wt(input int k);
    repeat (k) @(negedge clk);
    s1 += k;
    s2 += k;
  endtask

  task automatic t2(input int p);  // toggle clk2 p cycles after its last toggle
    wt(p - s2);
    clk2 = ~clk2;
    s2 = 0;
  endtask

  task automatic t2_now();
    wt(1);
    clk2 = ~clk2;
    s2 = 0;
  endtask

  task automatic t1(input int p);
    wt(p - s1);
    clk1 = ~clk1;
    s1 = 0;
  endtask

  task automatic t1_now();
    wt(1);
    clk1 = ~clk1;
    s1 = 0;
  endtask

  // ------------------------------------------------------- main
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (o_det_update) det_cnt++;
        if (o_mismatch) mism_cnt++;
        if (!rst && exp_q.size() == 3) begin
          cmp_e = exp_q[0];
          chk("m_prog", int'(o_prog_det), int'(cmp_e.prog));
          chk("m_locked", int'(o_locked), int'(cmp_e.locked));
          chk("m_det", int'(o_det_update), int'(cmp_e.det));
          chk("m_mism", int'(o_mismatch), int'(cmp_e.mism));
          chk("m_stall", int'(o_stall), int'(cmp_e.stall));
          chk("m_half", int'(o_half_period), int'(cmp_e.half));
          chk("m_f1", int'(o_clk1_fault), int'(cmp_e.f1));
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_prog", int'(o_prog_det), 0);
    chk("rst_locked", int'(o_locked), 0);
    chk("rst_stall", int'(o_stall), 0);
    chk("rst_half", int'(o_half_period), 0);
    chk("rst_f1", int'(o_clk1_fault), 0);
    rst = 1'b0;
    s1 = 0; s2 = 0;
    wt(2);

`ifdef FREQ_MON_CLK1_CHECK_EN
    t1_now();
    repeat (4) t1(8);
    wt(4);  chk("c1_ok", int'(o_clk1_fault), 0);
    t1(9);
    wt(4);  chk("c1_fault_9", int'(o_clk1_fault), 1);
    t1(8);
    wt(4);  chk("c1_one_good", int'(o_clk1_fault), 1);
    t1(8);
    wt(4);  chk("c1_cleared", int'(o_clk1_fault), 0);
    wt(20);
`endif

    // Lock on code 2
    det_cnt = 0; mism_cnt = 0;
    t2_now();
    t2(32);
    wt(4);  chk("lk_first_locked", int'(o_locked), 0);
            chk("lk_first_half", int'(o_half_period), 32);
    t2(32);
    wt(4);  chk("lk_prog", int'(o_prog_det), 2);
            chk("lk_locked", int'(o_locked), 1);
            chk("lk_half", int'(o_half_period), 32);
            chk("lk_det_cnt", det_cnt, 1);

    // Code change to 4
    det_cnt = 0;
    t2(100);
    wt(4);  chk("cc_unlock", int'(o_locked), 0);
            chk("cc_prog_hold", int'(o_prog_det), 2);
            chk("cc_half", int'(o_half_period), 100);
    t2(100);
    wt(4);  chk("cc_prog", int'(o_prog_det), 4);
            chk("cc_locked", int'(o_locked), 1);
            chk("cc_det_cnt", det_cnt, 1);

    // Window boundaries around code 2
    t2(32);
    t2(32);
    wt(4);  chk("wb_relock_prog", int'(o_prog_det), 2);
            chk("wb_relock", int'(o_locked), 1);
    det_cnt = 0; mism_cnt = 0;
    repeat (2) begin t2(34); t2(30); end
    wt(4);  chk("wb_edges_locked", int'(o_locked), 1);
            chk("wb_edges_mism", mism_cnt, 0);
            chk("wb_edges_det", det_cnt, 0);
            chk("wb_edges_half", int'(o_half_period), 30);
    t2(35);
    wt(4);  chk("wb_35_mism", mism_cnt, 1);
            chk("wb_35_locked", int'(o_locked), 0);
            chk("wb_35_prog", int'(o_prog_det), 2);
            chk("wb_35_half", int'(o_half_period), 35);

    // Stall
    t2(32);
    t2(32);
    wt(4);  chk("st_locked", int'(o_locked), 1);
    wt(849); chk("st_before", int'(o_stall), 0);
    wt(1);  chk("st_stall", int'(o_stall), 1);
            chk("st_unlock", int'(o_locked), 0);
            chk("st_prog", int'(o_prog_det), 2);
            chk("st_mism", mism_cnt, 1);
    t2_now();
    wt(4);  chk("st_clear", int'(o_stall), 0);
    t2(64);
    t2(64);
    wt(4);  chk("st_resume_prog", int'(o_prog_det), 3);
            chk("st_resume_lock", int'(o_locked), 1);
            chk("st_resume_half", int'(o_half_period), 64);

    // Asynchronous reset mid-interval
    t2(64);
    wt(20);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("ar_prog", int'(o_prog_det), 0);
    chk("ar_locked", int'(o_locked), 0);
    chk("ar_half", int'(o_half_period), 0);
    chk("ar_stall", int'(o_stall), 0);
    clk2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    s2 = 0;
    t2_now();
    wt(4);  chk("ar_discard_half", int'(o_half_period), 0);
    t2(64);
    wt(4);  chk("ar_meas_half", int'(o_half_period), 64);
            chk("ar_meas_locked", int'(o_locked), 0);
    t2(64);
    wt(4);  chk("ar_relock", int'(o_locked), 1);
            chk("ar_relock_prog", int'(o_prog_det), 3);

    wt(10);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
